// File: rtl/iob_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_bus_arb_pkg
// Description : Shared definitions for the two-master bus arbiter: FSM state
//               encoding, master index constants and strobe-width derivation.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package iob_bus_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // One strobe bit per data byte.
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_bus_arb_slot.sv
`default_nettype none
// ============================================================================
// Module      : iob_bus_arb_slot
// Description : One-entry request slot for a single master. Captures a request
//               pulse, presents it to the arbiter until granted, and frees the
//               slot in the cycle the master's ready is delivered.
// Ports       : clk, rst (async active-low)
//               valid/addr/wdata/wstrb - master request pulse
//               done                   - master ready this cycle (slot frees)
//               grant                  - arbiter issues this slot this cycle
//               req, req_addr/wdata/wstrb - request presented to the arbiter
//               violation              - request dropped (slot occupied)
// Revision    : 1.0 - initial release
// ============================================================================
module iob_bus_arb_slot
    import iob_bus_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [strb_width(DATA_W)-1:0] wstrb,
    input  logic                          done,
    input  logic                          grant,
    output logic                          req,
    output logic [ADDR_W-1:0]             req_addr,
    output logic [DATA_W-1:0]             req_wdata,
    output logic [strb_width(DATA_W)-1:0] req_wstrb,
    output logic                          violation
);

    logic                          r_occupied;
    logic                          r_issued;
    logic [ADDR_W-1:0]             r_addr;
    logic [DATA_W-1:0]             r_wdata;
    logic [strb_width(DATA_W)-1:0] r_wstrb;

    logic w_accept;
    logic w_pending;

    // The ready cycle frees the slot, so a new pulse landing in it is taken.
    assign w_accept  = valid & (~r_occupied | done);
    assign w_pending = r_occupied & ~r_issued;
    assign violation = valid & r_occupied & ~done;

    // A fresh pulse is offered straight from the inputs so it can be issued
    // in its own cycle; a stored request is offered from the slot registers.
    assign req       = w_pending | w_accept;
    assign req_addr  = w_pending ? r_addr  : addr;
    assign req_wdata = w_pending ? r_wdata : wdata;
    assign req_wstrb = w_pending ? r_wstrb : wstrb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occupied <= 1'b0;
            r_issued   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else if (w_accept) begin
            r_occupied <= 1'b1;
            r_issued   <= grant;
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_wstrb    <= wstrb;
        end else begin
            if (done) begin
                r_occupied <= 1'b0;
            end
            if (grant) begin
                r_issued <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iob_bus_arb2.sv
`default_nettype none
// ============================================================================
// Module      : iob_bus_arb2
// Description : Round-robin arbiter sharing one memory port between two
//               masters (CPU instruction and data buses). One transaction is
//               outstanding on the shared port at a time.
// Ports       : clk, rst (async active-low)
//               m0_*/m1_* valid,addr,wdata,wstrb in; rdata,ready out
//               s_* valid,addr,wdata,wstrb out; rdata,ready in
//               err - sticky protocol-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module iob_bus_arb2
    import iob_bus_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_valid,
    input  logic [ADDR_W-1:0]             m0_addr,
    input  logic [DATA_W-1:0]             m0_wdata,
    input  logic [strb_width(DATA_W)-1:0] m0_wstrb,
    output logic [DATA_W-1:0]             m0_rdata,
    output logic                          m0_ready,
    input  logic                          m1_valid,
    input  logic [ADDR_W-1:0]             m1_addr,
    input  logic [DATA_W-1:0]             m1_wdata,
    input  logic [strb_width(DATA_W)-1:0] m1_wstrb,
    output logic [DATA_W-1:0]             m1_rdata,
    output logic                          m1_ready,
    output logic                          s_valid,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [strb_width(DATA_W)-1:0] s_wstrb,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_ready,
    output logic                          err
);

    localparam int STRB_W = strb_width(DATA_W);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       r_prio;
    logic       r_owner;

    logic w_issue;
    logic w_sel;
    logic w_grant0;
    logic w_grant1;
    logic w_complete;
    logic w_idle_ready;

    logic              w_req0;
    logic              w_req1;
    logic              w_viol0;
    logic              w_viol1;
    logic [ADDR_W-1:0] w_addr0;
    logic [ADDR_W-1:0] w_addr1;
    logic [DATA_W-1:0] w_wdata0;
    logic [DATA_W-1:0] w_wdata1;
    logic [STRB_W-1:0] w_wstrb0;
    logic [STRB_W-1:0] w_wstrb1;

    iob_bus_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .valid     (m0_valid),
        .addr      (m0_addr),
        .wdata     (m0_wdata),
        .wstrb     (m0_wstrb),
        .done      (m0_ready),
        .grant     (w_grant0),
        .req       (w_req0),
        .req_addr  (w_addr0),
        .req_wdata (w_wdata0),
        .req_wstrb (w_wstrb0),
        .violation (w_viol0)
    );

    iob_bus_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .valid     (m1_valid),
        .addr      (m1_addr),
        .wdata     (m1_wdata),
        .wstrb     (m1_wstrb),
        .done      (m1_ready),
        .grant     (w_grant1),
        .req       (w_req1),
        .req_addr  (w_addr1),
        .req_wdata (w_wdata1),
        .req_wstrb (w_wstrb1),
        .violation (w_viol1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_sel        = M0;
        w_complete   = 1'b0;
        w_idle_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle_ready = s_ready;
                if (w_req0 | w_req1) begin
                    w_issue      = 1'b1;
                    // On a tie the priority pointer decides.
                    w_sel        = (w_req0 & w_req1) ? r_prio : (w_req0 ? M0 : M1);
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (s_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_grant0 = w_issue & (w_sel == M0);
    assign w_grant1 = w_issue & (w_sel == M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid  <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            r_owner  <= M0;
            r_prio   <= M0;
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            err      <= 1'b0;
        end else begin
            s_valid <= w_issue;
            if (w_issue) begin
                s_addr  <= (w_sel == M1) ? w_addr1  : w_addr0;
                s_wdata <= (w_sel == M1) ? w_wdata1 : w_wdata0;
                s_wstrb <= (w_sel == M1) ? w_wstrb1 : w_wstrb0;
                r_owner <= w_sel;
                // The master just served yields the next tie.
                r_prio  <= (w_sel == M0) ? M1 : M0;
            end
            m0_ready <= w_complete & (r_owner == M0);
            m1_ready <= w_complete & (r_owner == M1);
            if (w_complete && (r_owner == M0)) begin
                m0_rdata <= s_rdata;
            end
            if (w_complete && (r_owner == M1)) begin
                m1_rdata <= s_rdata;
            end
            err <= err | w_viol0 | w_viol1 | w_idle_ready;
        end
    end

endmodule
`default_nettype wire
